// File: rtl/fakeram130_64x15_arbiter_pkg.sv
// Shared types for the 64x15 fakeram130 access controller: FSM states and
// the per-requester request record.
package fakeram130_64x15_arbiter_pkg;

    localparam int els_lp        = 64;
    localparam int width_lp      = 15;
    localparam int addr_width_lp = 6;

    typedef enum logic {
        e_init,
        e_ready
    } state_e;

    typedef struct packed {
        logic                     w;
        logic [addr_width_lp-1:0] addr;
        logic [width_lp-1:0]      data;
        logic [width_lp-1:0]      mask;
    } req_s;

endpackage

// File: rtl/bsg_arb_round_robin.sv
// Round-robin arbiter, v/yumi flavour: the first request at or after the
// internal pointer wins; the pointer moves past the winner when yumi_i is set.
module bsg_arb_round_robin #(
    parameter int width_p = 2
) (
    input  logic                       clk_i,
    input  logic                       reset_i,
    input  logic [width_p-1:0]         reqs_i,
    input  logic                       yumi_i,
    output logic [width_p-1:0]         grants_o,
    output logic [$clog2(width_p)-1:0] tag_o,
    output logic                       v_o
);

    localparam int ptr_w_lp = $clog2(width_p);

    logic [ptr_w_lp-1:0] rr_ptr_q;
    logic [ptr_w_lp-1:0] sel;
    int                  idx;

    always_comb begin
        grants_o = '0;
        tag_o    = '0;
        v_o      = 1'b0;
        idx      = 0;
        sel      = '0;
        for (int i = 0; i < width_p; i++) begin
            idx = int'(rr_ptr_q) + i;
            if (idx >= width_p) idx = idx - width_p;
            sel = ptr_w_lp'(idx);
            if (!v_o && reqs_i[sel]) begin
                v_o           = 1'b1;
                grants_o[sel] = 1'b1;
                tag_o         = sel;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            rr_ptr_q <= '0;
        end else if (yumi_i && v_o) begin
            rr_ptr_q <= (tag_o == ptr_w_lp'(width_p-1)) ? '0 : tag_o + 1'b1;
        end
    end

endmodule

// File: rtl/fakeram130_64x15_arbiter.sv
// Shared-access controller for one 64x15 fakeram130 macro: clears the array
// after reset, then round-robins requesters onto the single port.
//
// state   | meaning
// e_init  | writing zero to address init_cnt_q, no grants
// e_ready | arbitrating requesters onto the macro
module fakeram130_64x15_arbiter
    import fakeram130_64x15_arbiter_pkg::*;
#(
    parameter int els_p        = els_lp,
    parameter int width_p      = width_lp,
    parameter int addr_width_p = addr_width_lp,
    parameter int num_req_p    = 2
) (
    input  logic                              clk_i,
    input  logic                              reset_i,
    input  logic [num_req_p-1:0]              v_i,
    input  logic [num_req_p-1:0]              w_i,
    input  logic [num_req_p*addr_width_p-1:0] addr_i,
    input  logic [num_req_p*width_p-1:0]      data_i,
    input  logic [num_req_p*width_p-1:0]      mask_i,
    output logic [num_req_p-1:0]              yumi_o,
    output logic [num_req_p-1:0]              v_o,
    output logic [width_p-1:0]                data_o,
    output logic                              init_done_o,
    output logic                              sram_ce_o,
    output logic                              sram_we_o,
    output logic [addr_width_p-1:0]           sram_addr_o,
    output logic [width_p-1:0]                sram_wd_o,
    output logic [width_p-1:0]                sram_w_mask_o,
    input  logic [width_p-1:0]                sram_rd_i
);

    localparam int tag_w_lp = $clog2(num_req_p);

    state_e                    state_q, state_n;
    logic [addr_width_p-1:0]   init_cnt_q;
    logic                      resp_v_q;
    logic [tag_w_lp-1:0]       resp_id_q;

    logic [num_req_p-1:0]      arb_reqs;
    logic [num_req_p-1:0]      arb_grants;
    logic [tag_w_lp-1:0]       arb_tag;
    logic                      arb_v;
    logic                      grant;
    req_s                      sel;

    // Requests are masked outside READY so the pointer never moves during clear.
    assign arb_reqs = (state_q == e_ready && !reset_i) ? v_i : '0;
    assign grant    = arb_v;

    bsg_arb_round_robin #(
        .width_p(num_req_p)
    ) rr (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .reqs_i  (arb_reqs),
        .yumi_i  (grant),
        .grants_o(arb_grants),
        .tag_o   (arb_tag),
        .v_o     (arb_v)
    );

    always_comb begin
        sel.w    = w_i[arb_tag];
        sel.addr = addr_i[int'(arb_tag)*addr_width_p +: addr_width_p];
        sel.data = data_i[int'(arb_tag)*width_p +: width_p];
        sel.mask = mask_i[int'(arb_tag)*width_p +: width_p];
    end

    always_comb begin
        state_n       = state_q;
        yumi_o        = '0;
        init_done_o   = 1'b0;
        sram_ce_o     = 1'b0;
        sram_we_o     = 1'b0;
        sram_addr_o   = '0;
        sram_wd_o     = '0;
        sram_w_mask_o = '0;
        if (!reset_i) begin
            case (state_q)
                e_init: begin
                    sram_ce_o     = 1'b1;
                    sram_we_o     = 1'b1;
                    sram_addr_o   = init_cnt_q;
                    sram_w_mask_o = '1;
                    if (init_cnt_q == addr_width_p'(els_p-1)) state_n = e_ready;
                end
                e_ready: begin
                    init_done_o = 1'b1;
                    if (grant) begin
                        yumi_o        = arb_grants;
                        sram_ce_o     = 1'b1;
                        sram_we_o     = sel.w;
                        sram_addr_o   = sel.addr;
                        sram_wd_o     = sel.data;
                        sram_w_mask_o = sel.mask;
                    end
                end
                default: state_n = e_init;
            endcase
        end
    end

    // The macro returns read data one cycle after ce, so the response simply
    // forwards sram_rd_i in the cycle after the grant.
    assign v_o    = (resp_v_q && !reset_i) ? (num_req_p'(1) << resp_id_q) : '0;
    assign data_o = sram_rd_i;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q    <= e_init;
            init_cnt_q <= '0;
            resp_v_q   <= 1'b0;
            resp_id_q  <= '0;
        end else begin
            state_q <= state_n;
            if (state_q == e_init) init_cnt_q <= init_cnt_q + 1'b1;
            resp_v_q  <= grant && !sel.w;
            resp_id_q <= arb_tag;
        end
    end

endmodule

// File: tb/tb_fakeram130_64x15_arbiter.sv
// Directed bench for fakeram130_64x15_arbiter with a behavioural macro model.
module tb_fakeram130_64x15_arbiter;

    logic        clk_i = 1'b0;
    logic        reset_i;
    logic [1:0]  v_i, w_i;
    logic [11:0] addr_i;
    logic [29:0] data_i, mask_i;
    logic [1:0]  yumi_o, v_o;
    logic [14:0] data_o;
    logic        init_done_o, sram_ce_o, sram_we_o;
    logic [5:0]  sram_addr_o;
    logic [14:0] sram_wd_o, sram_w_mask_o, sram_rd_i;

    int pass_cnt = 0;
    int total_cnt = 0;

    always #5 clk_i = ~clk_i;

    fakeram130_64x15_arbiter dut (
        .clk_i        (clk_i),
        .reset_i      (reset_i),
        .v_i          (v_i),
        .w_i          (w_i),
        .addr_i       (addr_i),
        .data_i       (data_i),
        .mask_i       (mask_i),
        .yumi_o       (yumi_o),
        .v_o          (v_o),
        .data_o       (data_o),
        .init_done_o  (init_done_o),
        .sram_ce_o    (sram_ce_o),
        .sram_we_o    (sram_we_o),
        .sram_addr_o  (sram_addr_o),
        .sram_wd_o    (sram_wd_o),
        .sram_w_mask_o(sram_w_mask_o),
        .sram_rd_i    (sram_rd_i)
    );

    // Macro model: pins captured on the falling edge, applied on the rising edge.
    logic [14:0] mem [64];
    logic        ce_s, we_s;
    logic [5:0]  addr_s;
    logic [14:0] wd_s, mask_s;

    initial for (int i = 0; i < 64; i++) mem[i] = 15'h5555;
    initial sram_rd_i = '0;

    always @(negedge clk_i) begin
        ce_s   = sram_ce_o;
        we_s   = sram_we_o;
        addr_s = sram_addr_o;
        wd_s   = sram_wd_o;
        mask_s = sram_w_mask_o;
    end

    always @(posedge clk_i) begin
        if (ce_s) begin
            if (we_s) mem[addr_s] <= (mem[addr_s] & ~mask_s) | (wd_s & mask_s);
            else      sram_rd_i   <= mem[addr_s];
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
        else pass_cnt++;
    endtask

    task automatic next_cycle();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive(input logic [1:0] v, input logic [1:0] w,
                         input logic [5:0] a0, input logic [5:0] a1,
                         input logic [14:0] d0, input logic [14:0] d1,
                         input logic [14:0] m0, input logic [14:0] m1);
        v_i    = v;
        w_i    = w;
        addr_i = {a1, a0};
        data_i = {d1, d0};
        mask_i = {m1, m0};
    endtask

    // Checks the 64 clear cycles starting in the current cycle (cycle 0).
    task automatic check_clear(input string tag);
        logic ok;
        ok = 1'b1;
        for (int k = 0; k < 64; k++) begin
            @(negedge clk_i);
            if (!(sram_ce_o === 1'b1 && sram_we_o === 1'b1 && sram_addr_o === 6'(k) &&
                  sram_wd_o === 15'h0 && sram_w_mask_o === 15'h7fff &&
                  yumi_o === 2'b00 && init_done_o === 1'b0 && v_o === 2'b00)) begin
                ok = 1'b0;
                $display("FAIL %s cycle %0d: ce=%b we=%b addr=%0d wd=%h mask=%h yumi=%b done=%b",
                         tag, k, sram_ce_o, sram_we_o, sram_addr_o, sram_wd_o,
                         sram_w_mask_o, yumi_o, init_done_o);
            end
            if (k != 63) next_cycle();
        end
        check({tag, "_seq"}, 64'(ok), 64'd1);
    endtask

    typedef struct {
        logic [1:0]  v, w;
        logic [5:0]  a0, a1;
        logic [14:0] d0, d1, m0, m1;
        logic [1:0]  exp_yumi, exp_v;
        logic [14:0] exp_data;
    } vec_t;

    vec_t vecs [18];

    initial begin
        //            v      w      a0  a1  d0        d1        m0        m1        yumi   v_o    data
        vecs[0]  = '{2'b01, 2'b01, 10, 0,  15'h0aaa, 15'h0,    15'h7fff, 15'h0,    2'b01, 2'b00, 15'h0};
        vecs[1]  = '{2'b10, 2'b10, 0,  20, 15'h0,    15'h1555, 15'h0,    15'h7fff, 2'b10, 2'b00, 15'h0};
        vecs[2]  = '{2'b11, 2'b00, 10, 20, 15'h0,    15'h0,    15'h0,    15'h0,    2'b01, 2'b00, 15'h0};
        vecs[3]  = '{2'b11, 2'b00, 10, 20, 15'h0,    15'h0,    15'h0,    15'h0,    2'b10, 2'b01, 15'h0aaa};
        vecs[4]  = '{2'b11, 2'b00, 10, 20, 15'h0,    15'h0,    15'h0,    15'h0,    2'b01, 2'b10, 15'h1555};
        vecs[5]  = '{2'b11, 2'b00, 10, 20, 15'h0,    15'h0,    15'h0,    15'h0,    2'b10, 2'b01, 15'h0aaa};
        vecs[6]  = '{2'b00, 2'b00, 0,  0,  15'h0,    15'h0,    15'h0,    15'h0,    2'b00, 2'b10, 15'h1555};
        vecs[7]  = '{2'b01, 2'b01, 5,  0,  15'h7fff, 15'h0,    15'h7fff, 15'h0,    2'b01, 2'b00, 15'h0};
        vecs[8]  = '{2'b01, 2'b01, 5,  0,  15'h0000, 15'h0,    15'h00ff, 15'h0,    2'b01, 2'b00, 15'h0};
        vecs[9]  = '{2'b01, 2'b00, 5,  0,  15'h0,    15'h0,    15'h0,    15'h0,    2'b01, 2'b00, 15'h0};
        vecs[10] = '{2'b00, 2'b00, 0,  0,  15'h0,    15'h0,    15'h0,    15'h0,    2'b00, 2'b01, 15'h7f00};
        vecs[11] = '{2'b10, 2'b10, 0,  63, 15'h0,    15'h1234, 15'h0,    15'h7fff, 2'b10, 2'b00, 15'h0};
        vecs[12] = '{2'b01, 2'b00, 63, 0,  15'h0,    15'h0,    15'h0,    15'h0,    2'b01, 2'b00, 15'h0};
        vecs[13] = '{2'b00, 2'b00, 0,  0,  15'h0,    15'h0,    15'h0,    15'h0,    2'b00, 2'b01, 15'h1234};
        vecs[14] = '{2'b11, 2'b01, 7,  7,  15'h0055, 15'h0,    15'h7fff, 15'h0,    2'b10, 2'b00, 15'h0};
        vecs[15] = '{2'b11, 2'b01, 7,  7,  15'h0055, 15'h0,    15'h7fff, 15'h0,    2'b01, 2'b10, 15'h0};
        vecs[16] = '{2'b10, 2'b00, 0,  7,  15'h0,    15'h0,    15'h0,    15'h0,    2'b10, 2'b00, 15'h0};
        vecs[17] = '{2'b00, 2'b00, 0,  0,  15'h0,    15'h0,    15'h0,    15'h0,    2'b00, 2'b10, 15'h0055};

        reset_i = 1'b1;
        drive(2'b11, 2'b00, 37, 37, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            next_cycle();
            @(negedge clk_i);
            check("reset_outputs_zero",
                  {yumi_o, v_o, init_done_o, sram_ce_o, sram_we_o, sram_addr_o, sram_wd_o, sram_w_mask_o},
                  64'd0);
        end

        next_cycle();
        reset_i = 1'b0;
        check_clear("clear");

        // Cycle 64: both requesters were waiting since cycle 0.
        next_cycle();
        @(negedge clk_i);
        check("done_at_64", 64'(init_done_o), 64'd1);
        check("first_grant_yumi", 64'(yumi_o), 64'b01);
        check("first_grant_addr", 64'(sram_addr_o), 64'd37);
        next_cycle();
        @(negedge clk_i);
        check("second_grant_yumi", 64'(yumi_o), 64'b10);
        check("read37_v0", 64'(v_o), 64'b01);
        check("read37_data0", 64'(data_o), 64'h0);
        next_cycle();
        drive(2'b00, 2'b00, 0, 0, 0, 0, 0, 0);
        @(negedge clk_i);
        check("read37_v1", 64'(v_o), 64'b10);
        check("read37_data1", 64'(data_o), 64'h0);
        check("idle_ce_low", 64'(sram_ce_o), 64'd0);

        foreach (vecs[i]) begin
            next_cycle();
            drive(vecs[i].v, vecs[i].w, vecs[i].a0, vecs[i].a1,
                  vecs[i].d0, vecs[i].d1, vecs[i].m0, vecs[i].m1);
            @(negedge clk_i);
            check($sformatf("vec%0d_yumi", i), 64'(yumi_o), 64'(vecs[i].exp_yumi));
            check($sformatf("vec%0d_ce", i), 64'(sram_ce_o), 64'(|vecs[i].exp_yumi));
            check($sformatf("vec%0d_v", i), 64'(v_o), 64'(vecs[i].exp_v));
            if (vecs[i].exp_v != 2'b00)
                check($sformatf("vec%0d_data", i), 64'(data_o), 64'(vecs[i].exp_data));
        end

        // Reset one cycle right after a read grant drops the pending response.
        next_cycle();
        drive(2'b01, 2'b00, 63, 0, 0, 0, 0, 0);
        @(negedge clk_i);
        check("pre_reset_grant", 64'(yumi_o), 64'b01);
        next_cycle();
        reset_i = 1'b1;
        drive(2'b00, 2'b00, 0, 0, 0, 0, 0, 0);
        @(negedge clk_i);
        check("midreset_v_o", 64'(v_o), 64'd0);
        next_cycle();
        reset_i = 1'b0;
        check_clear("reclear");
        next_cycle();
        @(negedge clk_i);
        check("redone_at_64", 64'(init_done_o), 64'd1);
        check("redone_v_o", 64'(v_o), 64'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
